// File: rtl/writeback_queue.sv
// -----------------------------------------------------------------------------
// writeback_queue
//
// In-order commit queue between the MEM stage and the GPR/CSR register files.
// MEM pushes fully decoded uops through a valid/ready handshake. Loads enter
// the queue without data and are filled later by in-order memory responses.
// The head entry is popped into a registered commit stage once its data is
// present, so at most one uop commits per cycle.
//
// Handshake: a uop transfers on the rising clock edge where mem_valid_i and
// mem_ready_o are both high. mem_ready_o depends only on queue occupancy
// (never on mem_valid_i) and is low whenever the queue is full, even if the
// head pops on that same edge.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   mem_valid_i/ready_o MEM uop handshake
//   mem_rd_i ...        uop fields: rd, GPR write enable, EXE result, load
//   mem_csr_data_i      flag, funct3, byte offset, CSR write enable/addr/data
//   d_m_rvalid_i/rdata_i load response (raw word, in load order)
//   valid_o             a uop commits this cycle
//   gpr_we_o/rd_o/gpr_wdata_o   GPR write port (rd_o is 0 unless gpr_we_o)
//   csr_we_o/csr_waddr_o/csr_wdata_o  CSR write port
//   pending_o           bit r set while an uncommitted GPR write to r is queued
//   count_o             number of occupied entries
//   err_o               sticky: a load response arrived with no load waiting
// -----------------------------------------------------------------------------
module writeback_queue #(
    parameter int DATA_WIDTH     = 32,
    parameter int RF_ADDR_WIDTH  = 5,
    parameter int CSR_ADDR_WIDTH = 12,
    parameter int DEPTH          = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             mem_valid_i,
    output logic                             mem_ready_o,
    input  logic [RF_ADDR_WIDTH-1:0]         mem_rd_i,
    input  logic                             mem_gpr_we_i,
    input  logic [DATA_WIDTH-1:0]            mem_exe_out_i,
    input  logic                             mem_is_load_i,
    input  logic [2:0]                       mem_funct3_i,
    input  logic [$clog2(DATA_WIDTH/8)-1:0]  mem_byte_off_i,
    input  logic                             mem_csr_we_i,
    input  logic [CSR_ADDR_WIDTH-1:0]        mem_csr_addr_i,
    input  logic [DATA_WIDTH-1:0]            mem_csr_data_i,
    input  logic                             d_m_rvalid_i,
    input  logic [DATA_WIDTH-1:0]            d_m_rdata_i,
    output logic                             valid_o,
    output logic                             gpr_we_o,
    output logic [RF_ADDR_WIDTH-1:0]         rd_o,
    output logic [DATA_WIDTH-1:0]            gpr_wdata_o,
    output logic                             csr_we_o,
    output logic [CSR_ADDR_WIDTH-1:0]        csr_waddr_o,
    output logic [DATA_WIDTH-1:0]            csr_wdata_o,
    output logic [2**RF_ADDR_WIDTH-1:0]      pending_o,
    output logic [$clog2(DEPTH):0]           count_o,
    output logic                             err_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OFF_W = $clog2(DATA_WIDTH / 8);
    localparam int NREG  = 2 ** RF_ADDR_WIDTH;

    if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_data_width
        $error("writeback_queue: DATA_WIDTH must be 32 or 64");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("writeback_queue: DEPTH must be a power of two >= 2");
    end

    // Queue storage. data_q holds the EXE result for non-loads and the raw
    // response word for loads once it has arrived.
    logic [RF_ADDR_WIDTH-1:0]  rd_q       [DEPTH];
    logic [DATA_WIDTH-1:0]     data_q     [DEPTH];
    logic [2:0]                funct3_q   [DEPTH];
    logic [OFF_W-1:0]          off_q      [DEPTH];
    logic [CSR_ADDR_WIDTH-1:0] csr_addr_q [DEPTH];
    logic [DATA_WIDTH-1:0]     csr_data_q [DEPTH];
    logic [DEPTH-1:0]          gpr_we_q;
    logic [DEPTH-1:0]          is_load_q;
    logic [DEPTH-1:0]          csr_we_q;
    logic [DEPTH-1:0]          data_ok_q;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;

    // Commit stage registers
    logic                      c_valid_q;
    logic                      c_gpr_we_q;
    logic [RF_ADDR_WIDTH-1:0]  c_rd_q;
    logic [DATA_WIDTH-1:0]     c_wdata_q;
    logic                      c_csr_we_q;
    logic [CSR_ADDR_WIDTH-1:0] c_csr_addr_q;
    logic [DATA_WIDTH-1:0]     c_csr_data_q;

    logic full, empty, push, pop;
    logic fill_found, fill, spurious;
    logic [PTR_W-1:0] fill_ptr, scan_idx, pend_idx;
    logic [NREG-1:0]  pending;
    logic [DATA_WIDTH-1:0] head_raw, head_shifted, head_ext, head_wdata;
    logic gpr_we_w;

    assign full        = (count_q == CNT_W'(DEPTH));
    assign empty       = (count_q == '0);
    assign mem_ready_o = !full;
    assign push        = mem_valid_i && !full;
    // A head load still waiting for its data blocks the queue.
    assign pop         = !empty && data_ok_q[head_q];

    // Oldest load still waiting for data. Only entries present before this
    // edge are scanned, so a response can never land in an entry being
    // enqueued on the same edge.
    always_comb begin
        fill_found = 1'b0;
        fill_ptr   = '0;
        scan_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PTR_W'(i);
            if (CNT_W'(i) < count_q && is_load_q[scan_idx] &&
                !data_ok_q[scan_idx] && !fill_found) begin
                fill_found = 1'b1;
                fill_ptr   = scan_idx;
            end
        end
    end

    assign fill     = d_m_rvalid_i && fill_found;
    assign spurious = d_m_rvalid_i && !fill_found;

    // Hazard mask over occupied entries; x0 never counts as a destination.
    always_comb begin
        pending  = '0;
        pend_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pend_idx = head_q + PTR_W'(i);
            if (CNT_W'(i) < count_q && gpr_we_q[pend_idx] && rd_q[pend_idx] != '0) begin
                pending[rd_q[pend_idx]] = 1'b1;
            end
        end
    end

    // Load extension of the head entry, applied on the way into the commit
    // stage. Sized casts of signed slices give the sign extension.
    assign head_raw     = data_q[head_q];
    assign head_shifted = head_raw >> {off_q[head_q], 3'b000};

    always_comb begin
        head_ext = head_raw;
        case (funct3_q[head_q])
            3'b000:  head_ext = DATA_WIDTH'($signed(head_shifted[7:0]));
            3'b001:  head_ext = DATA_WIDTH'($signed(head_shifted[15:0]));
            3'b010:  head_ext = DATA_WIDTH'($signed(head_shifted[31:0]));
            3'b100:  head_ext = DATA_WIDTH'(head_shifted[7:0]);
            3'b101:  head_ext = DATA_WIDTH'(head_shifted[15:0]);
            3'b011:  head_ext = (DATA_WIDTH == 64) ? head_shifted : head_raw;
            3'b110:  head_ext = (DATA_WIDTH == 64) ? DATA_WIDTH'(head_shifted[31:0]) : head_raw;
            default: head_ext = head_raw;
        endcase
    end

    assign head_wdata = is_load_q[head_q] ? head_ext : head_raw;

    always_comb begin
        head_d  = pop  ? head_q + 1'b1 : head_q;
        tail_d  = push ? tail_q + 1'b1 : tail_q;
        err_d   = err_q | spurious;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Queue state. Push and fill never target the same slot: the fill
    // target is an occupied entry, the push target is free.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
            gpr_we_q  <= '0;
            is_load_q <= '0;
            csr_we_q  <= '0;
            data_ok_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]       <= '0;
                data_q[i]     <= '0;
                funct3_q[i]   <= '0;
                off_q[i]      <= '0;
                csr_addr_q[i] <= '0;
                csr_data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
            if (push) begin
                rd_q[tail_q]       <= mem_rd_i;
                data_q[tail_q]     <= mem_exe_out_i;
                funct3_q[tail_q]   <= mem_funct3_i;
                off_q[tail_q]      <= mem_byte_off_i;
                csr_addr_q[tail_q] <= mem_csr_addr_i;
                csr_data_q[tail_q] <= mem_csr_data_i;
                gpr_we_q[tail_q]   <= mem_gpr_we_i;
                is_load_q[tail_q]  <= mem_is_load_i;
                csr_we_q[tail_q]   <= mem_csr_we_i;
                data_ok_q[tail_q]  <= !mem_is_load_i;
            end
            if (fill) begin
                data_q[fill_ptr]    <= d_m_rdata_i;
                data_ok_q[fill_ptr] <= 1'b1;
            end
        end
    end

    // Commit stage: holds the popped uop for exactly one cycle, zero otherwise.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            c_valid_q    <= 1'b0;
            c_gpr_we_q   <= 1'b0;
            c_rd_q       <= '0;
            c_wdata_q    <= '0;
            c_csr_we_q   <= 1'b0;
            c_csr_addr_q <= '0;
            c_csr_data_q <= '0;
        end else if (pop) begin
            c_valid_q    <= 1'b1;
            c_gpr_we_q   <= gpr_we_q[head_q];
            c_rd_q       <= rd_q[head_q];
            c_wdata_q    <= head_wdata;
            c_csr_we_q   <= csr_we_q[head_q];
            c_csr_addr_q <= csr_addr_q[head_q];
            c_csr_data_q <= csr_data_q[head_q];
        end else begin
            c_valid_q    <= 1'b0;
            c_gpr_we_q   <= 1'b0;
            c_rd_q       <= '0;
            c_wdata_q    <= '0;
            c_csr_we_q   <= 1'b0;
            c_csr_addr_q <= '0;
            c_csr_data_q <= '0;
        end
    end

    assign gpr_we_w    = c_valid_q && c_gpr_we_q && (c_rd_q != '0);
    assign valid_o     = c_valid_q;
    assign gpr_we_o    = gpr_we_w;
    assign rd_o        = gpr_we_w ? c_rd_q : '0;
    assign gpr_wdata_o = c_wdata_q;
    assign csr_we_o    = c_valid_q && c_csr_we_q;
    assign csr_waddr_o = c_csr_addr_q;
    assign csr_wdata_o = c_csr_data_q;
    assign pending_o   = pending;
    assign count_o     = count_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_writeback_queue.sv
// -----------------------------------------------------------------------------
// tb_writeback_queue
//
// Directed scenarios followed by randomized traffic. A queue-level model of
// the commit queue predicts every output; compare_all checks the DUT against
// it once per cycle on the falling edge.
// -----------------------------------------------------------------------------
module tb_writeback_queue;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int CW    = 12;
    localparam int DEPTH = 4;
    localparam int OW    = $clog2(DW / 8);

    logic                clk;
    logic                rst_i;
    logic                mem_valid_i;
    logic                mem_ready_o;
    logic [AW-1:0]       mem_rd_i;
    logic                mem_gpr_we_i;
    logic [DW-1:0]       mem_exe_out_i;
    logic                mem_is_load_i;
    logic [2:0]          mem_funct3_i;
    logic [OW-1:0]       mem_byte_off_i;
    logic                mem_csr_we_i;
    logic [CW-1:0]       mem_csr_addr_i;
    logic [DW-1:0]       mem_csr_data_i;
    logic                d_m_rvalid_i;
    logic [DW-1:0]       d_m_rdata_i;
    logic                valid_o;
    logic                gpr_we_o;
    logic [AW-1:0]       rd_o;
    logic [DW-1:0]       gpr_wdata_o;
    logic                csr_we_o;
    logic [CW-1:0]       csr_waddr_o;
    logic [DW-1:0]       csr_wdata_o;
    logic [2**AW-1:0]    pending_o;
    logic [$clog2(DEPTH):0] count_o;
    logic                err_o;

    writeback_queue #(
        .DATA_WIDTH(DW), .RF_ADDR_WIDTH(AW), .CSR_ADDR_WIDTH(CW), .DEPTH(DEPTH)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o),
        .mem_rd_i(mem_rd_i), .mem_gpr_we_i(mem_gpr_we_i),
        .mem_exe_out_i(mem_exe_out_i), .mem_is_load_i(mem_is_load_i),
        .mem_funct3_i(mem_funct3_i), .mem_byte_off_i(mem_byte_off_i),
        .mem_csr_we_i(mem_csr_we_i), .mem_csr_addr_i(mem_csr_addr_i),
        .mem_csr_data_i(mem_csr_data_i),
        .d_m_rvalid_i(d_m_rvalid_i), .d_m_rdata_i(d_m_rdata_i),
        .valid_o(valid_o), .gpr_we_o(gpr_we_o), .rd_o(rd_o),
        .gpr_wdata_o(gpr_wdata_o), .csr_we_o(csr_we_o),
        .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
        .pending_o(pending_o), .count_o(count_o), .err_o(err_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    typedef struct {
        logic [AW-1:0] rd;
        logic          gpr_we;
        logic [DW-1:0] exe;
        logic          is_load;
        logic [2:0]    f3;
        logic [OW-1:0] off;
        logic          csr_we;
        logic [CW-1:0] caddr;
        logic [DW-1:0] cdata;
        logic          data_ok;
        logic [DW-1:0] rdata;
    } ent_t;

    ent_t          exp_q[$];
    logic          m_valid, m_gpr_we, m_csr_we, m_err;
    logic [AW-1:0] m_rd;
    logic [DW-1:0] m_wdata, m_cdata;
    logic [CW-1:0] m_caddr;

    int vectors    = 0;
    int miscompares = 0;

    // Load result from the ISA rules, using plain integer arithmetic.
    function automatic logic [DW-1:0] ext_model(input logic [DW-1:0] raw,
                                                input logic [2:0] f3,
                                                input logic [OW-1:0] off);
        longint unsigned u;
        longint          v;
        u = 64'(raw) >> (int'(off) * 8);
        case (f3)
            3'd0: begin v = longint'(u & 64'hFF);   if (v > 127)   v = v - 256; end
            3'd1: begin v = longint'(u & 64'hFFFF); if (v > 32767) v = v - 65536; end
            3'd2: begin
                v = longint'(u & 64'hFFFF_FFFF);
                if (v > 64'sd2147483647) v = v - 64'sd4294967296;
            end
            3'd4: v = longint'(u & 64'hFF);
            3'd5: v = longint'(u & 64'hFFFF);
            3'd3: begin if (DW == 64) v = longint'(u); else v = longint'(64'(raw)); end
            3'd6: begin if (DW == 64) v = longint'(u & 64'hFFFF_FFFF); else v = longint'(64'(raw)); end
            default: v = longint'(64'(raw));
        endcase
        return DW'(v);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_valid = 1'b0; m_gpr_we = 1'b0; m_csr_we = 1'b0; m_err = 1'b0;
        m_rd = '0; m_wdata = '0; m_cdata = '0; m_caddr = '0;
    endtask

    function automatic bit model_has_waiting_load();
        foreach (exp_q[i]) if (exp_q[i].is_load && !exp_q[i].data_ok) return 1'b1;
        return 1'b0;
    endfunction

    // One clock edge of the queue, given the inputs held across that edge.
    task automatic model_step();
        int   pre;
        int   fi;
        bit   do_pop;
        ent_t e;
        pre    = exp_q.size();
        do_pop = (pre > 0) && exp_q[0].data_ok;
        if (d_m_rvalid_i) begin
            fi = -1;
            for (int i = 0; i < pre; i++)
                if (fi < 0 && exp_q[i].is_load && !exp_q[i].data_ok) fi = i;
            if (fi >= 0) begin
                e = exp_q[fi];
                e.rdata = d_m_rdata_i;
                e.data_ok = 1'b1;
                exp_q[fi] = e;
            end else begin
                m_err = 1'b1;
            end
        end
        m_valid = 1'b0; m_gpr_we = 1'b0; m_csr_we = 1'b0;
        m_rd = '0; m_wdata = '0; m_cdata = '0; m_caddr = '0;
        if (do_pop) begin
            e = exp_q.pop_front();
            m_valid  = 1'b1;
            m_gpr_we = e.gpr_we && (e.rd != 0);
            m_rd     = m_gpr_we ? e.rd : '0;
            m_wdata  = e.is_load ? ext_model(e.rdata, e.f3, e.off) : e.exe;
            m_csr_we = e.csr_we;
            m_caddr  = e.caddr;
            m_cdata  = e.cdata;
        end
        if (mem_valid_i && pre < DEPTH) begin
            e.rd = mem_rd_i; e.gpr_we = mem_gpr_we_i; e.exe = mem_exe_out_i;
            e.is_load = mem_is_load_i; e.f3 = mem_funct3_i; e.off = mem_byte_off_i;
            e.csr_we = mem_csr_we_i; e.caddr = mem_csr_addr_i; e.cdata = mem_csr_data_i;
            e.data_ok = !mem_is_load_i; e.rdata = '0;
            exp_q.push_back(e);
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, want, $time);
        end
    endtask

    task automatic compare_all();
        logic [2**AW-1:0] p;
        p = '0;
        foreach (exp_q[i]) if (exp_q[i].gpr_we && exp_q[i].rd != 0) p[exp_q[i].rd] = 1'b1;
        check("valid_o",     64'(valid_o),     64'(m_valid));
        check("gpr_we_o",    64'(gpr_we_o),    64'(m_gpr_we));
        check("rd_o",        64'(rd_o),        64'(m_rd));
        check("csr_we_o",    64'(csr_we_o),    64'(m_csr_we));
        check("count_o",     64'(count_o),     64'(exp_q.size()));
        check("mem_ready_o", 64'(mem_ready_o), 64'(exp_q.size() < DEPTH));
        check("pending_o",   64'(pending_o),   64'(p));
        check("err_o",       64'(err_o),       64'(m_err));
        if (m_valid) begin
            check("gpr_wdata_o", 64'(gpr_wdata_o), 64'(m_wdata));
            check("csr_waddr_o", 64'(csr_waddr_o), 64'(m_caddr));
            check("csr_wdata_o", 64'(csr_wdata_o), 64'(m_cdata));
        end
    endtask

    // ---------------- driver ----------------
    task automatic set_uop(input logic v, input logic [AW-1:0] rd, input logic gwe,
                           input logic [DW-1:0] exe, input logic ld, input logic [2:0] f3,
                           input logic [OW-1:0] off, input logic cwe,
                           input logic [CW-1:0] caddr, input logic [DW-1:0] cdata);
        mem_valid_i = v; mem_rd_i = rd; mem_gpr_we_i = gwe; mem_exe_out_i = exe;
        mem_is_load_i = ld; mem_funct3_i = f3; mem_byte_off_i = off;
        mem_csr_we_i = cwe; mem_csr_addr_i = caddr; mem_csr_data_i = cdata;
    endtask

    task automatic idle();
        set_uop(1'b0, '0, 1'b0, '0, 1'b0, 3'd0, '0, 1'b0, '0, '0);
        d_m_rvalid_i = 1'b0;
        d_m_rdata_i  = '0;
    endtask

    // Inputs are set at the falling edge; the model advances just after the
    // rising edge; outputs are compared at the next falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!rst_i) model_step();
        @(negedge clk);
        compare_all();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_i = 1'b1;
        idle();
        model_reset();

        // Model pins: hand-computed load extensions.
        check("pin_lb",  64'(ext_model(32'h0080_0000, 3'd0, 2'd2)), 64'h0000_0000_FFFF_FF80);
        check("pin_lh",  64'(ext_model(32'h8001_0000, 3'd1, 2'd2)), 64'h0000_0000_FFFF_8001);
        check("pin_lbu", 64'(ext_model(32'hAB00_0000, 3'd4, 2'd3)), 64'h0000_0000_0000_00AB);
        check("pin_lhu", 64'(ext_model(32'h1234_F00D, 3'd5, 2'd0)), 64'h0000_0000_0000_F00D);
        check("pin_raw", 64'(ext_model(32'hCAFE_BABE, 3'd7, 2'd1)), 64'h0000_0000_CAFE_BABE);

        // Reset state
        tick();
        tick();
        rst_i = 1'b0;
        tick();
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_ready", 64'(mem_ready_o), 64'd1);
        check("rst_valid", 64'(valid_o), 64'd0);

        // ALU uop: rd=5, 0x1234; no bypass
        set_uop(1'b1, 5'd5, 1'b1, 32'h1234, 1'b0, 3'd0, 2'd0, 1'b0, '0, '0);
        tick();
        idle();
        check("alu_nobypass", 64'(valid_o), 64'd0);
        check("alu_pending", 64'(pending_o), 64'h20);
        tick();
        check("alu_valid", 64'(valid_o), 64'd1);
        check("alu_gpr_we", 64'(gpr_we_o), 64'd1);
        check("alu_rd", 64'(rd_o), 64'd5);
        check("alu_wdata", 64'(gpr_wdata_o), 64'h1234);
        tick();
        check("alu_one_cycle", 64'(valid_o), 64'd0);

        // LB byte_off=2 with the response 3 cycles late
        set_uop(1'b1, 5'd7, 1'b1, 32'h0, 1'b1, 3'd0, 2'd2, 1'b0, '0, '0);
        tick();
        idle();
        repeat (3) begin
            tick();
            check("lb_stall", 64'(valid_o), 64'd0);
        end
        check("lb_count", 64'(count_o), 64'd1);
        d_m_rvalid_i = 1'b1;
        d_m_rdata_i  = 32'h0080_0000;
        tick();
        idle();
        tick();
        check("lb_valid", 64'(valid_o), 64'd1);
        check("lb_rd", 64'(rd_o), 64'd7);
        check("lb_wdata", 64'(gpr_wdata_o), 64'hFFFF_FF80);

        // Fill all entries with loads, no responses
        for (int i = 1; i <= DEPTH; i++) begin
            set_uop(1'b1, AW'(i), 1'b1, '0, 1'b1, 3'd2, 2'd0, 1'b0, '0, '0);
            tick();
        end
        check("full_ready", 64'(mem_ready_o), 64'd0);
        check("full_count", 64'(count_o), 64'(DEPTH));
        check("full_pending", 64'(pending_o), 64'h1E);
        set_uop(1'b1, 5'd9, 1'b1, '0, 1'b0, 3'd0, 2'd0, 1'b0, '0, '0);
        tick();
        idle();
        check("full_no_accept", 64'(count_o), 64'(DEPTH));
        for (int j = 0; j <= DEPTH; j++) begin
            d_m_rvalid_i = (j < DEPTH);
            d_m_rdata_i  = 32'hA000_0000 + DW'(j);
            tick();
            check("drain_valid", 64'(valid_o), 64'(j > 0));
            check("drain_rd", 64'(rd_o), 64'(j));
        end
        idle();
        check("drain_last_wdata", 64'(gpr_wdata_o), 64'hA000_0003);

        // rd=0 with a CSR write
        set_uop(1'b1, 5'd0, 1'b1, 32'hDEAD, 1'b0, 3'd0, 2'd0, 1'b1, 12'h300, 32'h8);
        tick();
        idle();
        tick();
        check("csr_gpr_we", 64'(gpr_we_o), 64'd0);
        check("csr_rd", 64'(rd_o), 64'd0);
        check("csr_we", 64'(csr_we_o), 64'd1);
        check("csr_waddr", 64'(csr_waddr_o), 64'h300);
        check("csr_wdata", 64'(csr_wdata_o), 64'h8);

        // Spurious response on an empty queue
        d_m_rvalid_i = 1'b1;
        d_m_rdata_i  = 32'h5555_5555;
        tick();
        idle();
        check("spur_err", 64'(err_o), 64'd1);
        check("spur_valid", 64'(valid_o), 64'd0);
        tick();
        check("spur_sticky", 64'(err_o), 64'd1);

        // Enqueue and pop on the same edge
        set_uop(1'b1, 5'd3, 1'b1, 32'h11, 1'b0, 3'd0, 2'd0, 1'b0, '0, '0);
        tick();
        set_uop(1'b1, 5'd4, 1'b1, 32'h22, 1'b0, 3'd0, 2'd0, 1'b0, '0, '0);
        tick();
        idle();
        check("enqpop_count", 64'(count_o), 64'd1);
        check("enqpop_rd", 64'(rd_o), 64'd3);
        tick();
        check("enqpop_rd2", 64'(rd_o), 64'd4);

        // Randomized traffic with a reset in the middle
        for (int n = 0; n < 3000; n++) begin
            set_uop(1'b0, '0, 1'b0, '0, 1'b0, 3'd0, '0, 1'b0, '0, '0);
            mem_valid_i    = ($urandom_range(0, 99) < 60);
            mem_rd_i       = AW'($urandom_range(0, 7));
            mem_gpr_we_i   = ($urandom_range(0, 3) != 0);
            mem_exe_out_i  = DW'($urandom);
            mem_is_load_i  = ($urandom_range(0, 1) == 1);
            mem_funct3_i   = 3'($urandom_range(0, 7));
            mem_byte_off_i = OW'($urandom_range(0, DW / 8 - 1));
            mem_csr_we_i   = ($urandom_range(0, 3) == 0);
            mem_csr_addr_i = CW'($urandom);
            mem_csr_data_i = DW'($urandom);
            if (model_has_waiting_load()) d_m_rvalid_i = ($urandom_range(0, 99) < 40);
            else                          d_m_rvalid_i = ($urandom_range(0, 199) == 0);
            d_m_rdata_i = DW'($urandom);
            tick();
            if (n == 1500) begin
                rst_i = 1'b1;
                #1;
                check("midrst_valid", 64'(valid_o), 64'd0);
                check("midrst_gpr_we", 64'(gpr_we_o), 64'd0);
                check("midrst_csr_we", 64'(csr_we_o), 64'd0);
                check("midrst_count", 64'(count_o), 64'd0);
                check("midrst_pending", 64'(pending_o), 64'd0);
                check("midrst_err", 64'(err_o), 64'd0);
                model_reset();
                tick();
                rst_i = 1'b0;
            end
        end

        // Drain
        idle();
        repeat (20) begin
            d_m_rvalid_i = model_has_waiting_load();
            d_m_rdata_i  = DW'($urandom);
            tick();
        end
        idle();
        tick();
        check("final_count", 64'(count_o), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
